// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word and round constants, message-schedule FSM
// encoding, and the small sigma functions used to extend the schedule.
package sha256_pkg;

  localparam int SHA_ROUNDS = 64;
  localparam int SHA_WINDOW = 16;
  localparam int SHA_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GEN   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [SHA_WORD_W-1:0] small_sigma0(input logic [SHA_WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [SHA_WORD_W-1:0] small_sigma1(input logic [SHA_WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha_small_sigma.sv
// Combinational pair of small sigmas: sigma0 of x0_i and sigma1 of x1_i.
module sha_small_sigma
  import sha256_pkg::*;
(
  input  logic [SHA_WORD_W-1:0] x0_i,
  input  logic [SHA_WORD_W-1:0] x1_i,
  output logic [SHA_WORD_W-1:0] s0_o,
  output logic [SHA_WORD_W-1:0] s1_o
);

  assign s0_o = small_sigma0(x0_i);
  assign s1_o = small_sigma1(x1_i);

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule: passes 16 block words through as W[0..15], then
// extends them to W[16..63] from a 16-word sliding window, one word per cycle.
module sha_msg_schedule
  import sha256_pkg::*;
#(
  parameter int DATA_W = SHA_WORD_W,
  parameter int ROUNDS = SHA_ROUNDS,
  parameter int WINDOW = SHA_WINDOW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic [1:0]        state_dbg_o
);

  // Handshakes: a word moves on a clock edge where valid and ready are both
  // high; a valid source holds its word stable until ready is seen.

  localparam logic [6:0] T_LOAD_LAST = 7'(WINDOW - 1);
  localparam logic [6:0] T_GEN_LAST  = 7'(ROUNDS - 1);

  sched_state_e      state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [DATA_W-1:0] win_q [WINDOW];
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;
  logic              done_q;

  logic              free;
  logic              in_ready_c;
  logic              load_in;
  logic              load_gen;
  logic              load_w;
  logic              drain_take;
  logic [DATA_W-1:0] sig0;
  logic [DATA_W-1:0] sig1;
  logic [DATA_W-1:0] gen_word;
  logic [DATA_W-1:0] new_word;

  // win_q[0] is W[t-16], win_q[WINDOW-1] is W[t-1].
  sha_small_sigma u_sigma (
    .x0_i (win_q[1]),
    .x1_i (win_q[WINDOW-2]),
    .s0_o (sig0),
    .s1_o (sig1)
  );

  assign gen_word = sig1 + win_q[WINDOW-7] + sig0 + win_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_LOAD;
          t_d     = '0;
        end
      end
      ST_LOAD: begin
        if (load_in) begin
          t_d = t_q + 7'd1;
          if (t_q == T_LOAD_LAST) state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        if (load_gen) begin
          t_d = t_q + 7'd1;
          if (t_q == T_GEN_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_take) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    free       = !out_valid_q || out_ready;
    in_ready_c = 1'b0;
    load_gen   = 1'b0;
    drain_take = 1'b0;
    case (state_q)
      ST_LOAD:  in_ready_c = free;
      ST_GEN:   load_gen   = free;
      ST_DRAIN: drain_take = out_valid_q && out_ready;
      default:  ;
    endcase
    load_in  = in_ready_c && in_valid;
    load_w   = load_in || load_gen;
    new_word = load_in ? in0 : gen_word;
  end

  // Output register and window advance together, so a stalled consumer also
  // freezes the schedule.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < WINDOW; i++) win_q[i] <= '0;
    end else begin
      done_q <= drain_take;
      if (load_w) begin
        out_q       <= new_word;
        out_valid_q <= 1'b1;
        for (int i = 0; i < WINDOW - 1; i++) win_q[i] <= win_q[i+1];
        win_q[WINDOW-1] <= new_word;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready    = in_ready_c;
  assign out0        = out_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: scoreboarded 64-word sequences from a reference
// model, a table of known schedule words, and reset/run/backpressure corners.
module tb_sha_msg_schedule;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] in0;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic [1:0]  state_dbg;

  sha_msg_schedule dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .in0         (in0),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out0        (out0),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .done        (done),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared state ----------------
  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] blocks  [3][16];
  logic [31:0] got_tab [3][64];
  logic [31:0] exp_q [$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_got   = 0;
  int   cur_kind = 0;
  bit   ready_rand = 1'b0;
  bit   blk_done = 1'b0;
  bit   stall_prev = 1'b0;
  bit   took_last = 1'b0;
  logic [31:0] held = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_expected(input int kind);
    logic [31:0] w [64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blocks[kind][t];
      else        w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
      exp_q.push_back(w[t]);
    end
  endtask

  // ---------------- output monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      out_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (rst) begin
        stall_prev = 1'b0;
        took_last  = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_hold", out0, held);
        end
        if (out_valid && !out_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (done || took_last) begin
          check("done_pulse", {31'd0, done}, {31'd0, took_last});
          if (done && took_last) begin
            check("word_count", n_got, 64);
            check("queue_empty", exp_q.size(), 0);
            blk_done = 1'b1;
          end
        end
        took_last = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_extra: got %08h with no word expected", out0);
          end else begin
            check($sformatf("sb_word_%0d", n_got), out0, exp_q.pop_front());
          end
          if (n_got < 64) got_tab[cur_kind][n_got] = out0;
          n_got++;
          took_last = (n_got == 64);
        end
        stall_prev = out_valid && !out_ready;
        held       = out0;
      end
    end
  end

  // ---------------- driver ----------------
  // mode 0: plain block, mode 1: extra run pulse mid-GEN, mode 2: reset mid-GEN.
  // Entered and left at negedge+2.
  task automatic run_block(input int kind, input bit rnd, input int mode);
    int i;
    int guard;
    bit hold;
    bit pulsed;
    cur_kind   = kind;
    ready_rand = rnd;
    n_got      = 0;
    blk_done   = 1'b0;
    push_expected(kind);
    @(negedge clk); #2;
    run = 1'b1;
    @(negedge clk); #2;
    run = 1'b0;
    i = 0; guard = 0; hold = 1'b0; pulsed = 1'b0;
    while (i < 16 && guard < 1000) begin
      if (!hold) begin
        if (rnd && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in0      = blocks[kind][i];
        end
      end
      #1;
      if (in_valid && in_ready) begin
        i++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      guard++;
      @(negedge clk); #2;
    end
    in_valid = 1'b0;
    in0      = '0;
    check("inputs_accepted", i, 16);
    guard = 0;
    while (!blk_done && guard < 500) begin
      run = 1'b0;
      if (mode == 1 && n_got == 30 && !pulsed) begin
        run    = 1'b1;
        pulsed = 1'b1;
      end
      if (mode == 2 && n_got >= 40) begin
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_state", {30'd0, state_dbg}, 32'd0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_got = 0;
        return;
      end
      @(negedge clk); #2;
      guard++;
    end
    run = 1'b0;
    check("block_done", {31'd0, blk_done}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 16; j++)
        blocks[k][j] = (k == 1) ? 32'hFFFF_FFFF : 32'h0;
    blocks[0][0]  = 32'h6162_6380;
    blocks[0][15] = 32'h0000_0018;

    // sigma1(all ones) reduces to SHR10 = 0x003FFFFF, sigma0 to SHR3 = 0x1FFFFFFF.
    vecs[0]  = '{0, 0,  32'h6162_6380};
    vecs[1]  = '{0, 1,  32'h0000_0000};
    vecs[2]  = '{0, 15, 32'h0000_0018};
    vecs[3]  = '{0, 16, 32'h6162_6380};
    vecs[4]  = '{0, 17, 32'h000F_0000};
    vecs[5]  = '{0, 63, 32'h12B1_EDEB};
    vecs[6]  = '{1, 0,  32'hFFFF_FFFF};
    vecs[7]  = '{1, 16, 32'h203F_FFFC};
    vecs[8]  = '{2, 16, 32'h0000_0000};
    vecs[9]  = '{2, 40, 32'h0000_0000};
    vecs[10] = '{2, 63, 32'h0000_0000};

    rst = 1'b1; run = 1'b0; in_valid = 1'b0; in0 = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out0", out0, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    in0      = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); #1;
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    #1;
    in_valid = 1'b0;
    in0      = '0;

    run_block(0, 1'b0, 0);
    run_block(0, 1'b1, 0);
    run_block(0, 1'b0, 1);
    run_block(2, 1'b0, 0);
    run_block(0, 1'b0, 2);
    run_block(0, 1'b0, 0);
    run_block(1, 1'b1, 0);

    for (int v = 0; v < 11; v++)
      check($sformatf("table_k%0d_w%0d", vecs[v].kind, vecs[v].idx),
            got_tab[vecs[v].kind][vecs[v].idx], vecs[v].exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
